pp_ram_mq: RTL and testbench

- Parametrised multi-slot frame buffer; successor to the 2-slot ping-pong RAM used between the CDBUS rx/tx framers and the host register interface.
- Writer fills the current write slot, then commits it with flags and length. Reader consumes committed slots in FIFO order.
- Adds over the previous generation: configurable data width, per-slot length capture, pending-count output, overwrite-oldest mode, write abort.

---
 rtl/pp_ram_mq_pkg.sv | 18 +
 rtl/pp_ram_mq_ctrl.sv | 114 +++++++++++
 rtl/pp_ram_mq.sv | 136 +++++++++++++
 tb/tb_pp_ram_mq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pp_ram_mq_pkg.sv
// Shared definitions for the pp_ram_mq multi-slot frame buffer.
//   slot_count()  : number of slots for a given slot index width
//   commit_res_e  : outcome of a commit attempt in one cycle
package pp_ram_mq_pkg;

  // Slot count S = 2**n_width.
  function automatic int unsigned slot_count(input int unsigned n_width);
    return 32'd1 << n_width;
  endfunction

  typedef enum logic [1:0] {
    CommitNone,
    CommitOk,
    CommitFail,
    CommitDrop
  } commit_res_e;

endpackage

// File: rtl/pp_ram_mq_ctrl.sv
// Slot bookkeeping for pp_ram_mq: write/read slot pointers, per-slot valid bits,
// pending counter and the flush > rd_done > commit > abort arbitration.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               return to empty (control state only)
//   rd_done             release oldest committed slot
//   commit, wr_abort    commit request; abort cancels a same-cycle commit
//   overwrite_en        when full, commit drops the oldest slot instead of failing
//   wr_sel, rd_sel      current write slot, oldest committed slot
//   pending             committed, unread slot count
//   store               capture flags/len into slot wr_sel this cycle
//   commit_fail, dropped  registered one-cycle pulses
module pp_ram_mq_ctrl
  import pp_ram_mq_pkg::*;
#(
  parameter int unsigned N_WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               rd_done,
  input  logic               commit,
  input  logic               wr_abort,
  input  logic               overwrite_en,
  output logic [N_WIDTH-1:0] wr_sel,
  output logic [N_WIDTH-1:0] rd_sel,
  output logic [N_WIDTH:0]   pending,
  output logic               store,
  output logic               commit_fail,
  output logic               dropped
);

  localparam int unsigned S = slot_count(N_WIDTH);
  localparam logic [N_WIDTH:0] Full = (N_WIDTH+1)'(S - 1);

  typedef logic [N_WIDTH-1:0] slot_idx_t;

  slot_idx_t        wr_sel_q, wr_sel_d;
  slot_idx_t        rd_sel_q, rd_sel_d;
  logic [N_WIDTH:0] pending_q, pending_d;
  logic [S-1:0]     valid_q, valid_d;
  logic             commit_fail_q, dropped_q;
  commit_res_e      res;

  always_comb begin
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    res       = CommitNone;
    store     = 1'b0;

    if (rd_done && (pending_q != '0)) begin
      valid_d[rd_sel_q] = 1'b0;
      rd_sel_d          = rd_sel_q + 1'b1;
      pending_d         = pending_q - 1'b1;
    end

    // Fullness is judged after the release above, so release+commit while full succeeds.
    if (commit && !wr_abort) begin
      if (pending_d != Full) begin
        store             = 1'b1;
        valid_d[wr_sel_q] = 1'b1;
        wr_sel_d          = wr_sel_q + 1'b1;
        pending_d         = pending_d + 1'b1;
        res               = CommitOk;
      end else if (overwrite_en) begin
        // The dropped oldest slot becomes the next write slot.
        store             = 1'b1;
        valid_d[wr_sel_q] = 1'b1;
        valid_d[rd_sel_d] = 1'b0;
        wr_sel_d          = wr_sel_q + 1'b1;
        rd_sel_d          = rd_sel_d + 1'b1;
        res               = CommitDrop;
      end else begin
        res = CommitFail;
      end
    end

    if (flush) begin
      wr_sel_d  = '0;
      rd_sel_d  = '0;
      pending_d = '0;
      valid_d   = '0;
      store     = 1'b0;
      res       = CommitNone;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel_q      <= '0;
      rd_sel_q      <= '0;
      pending_q     <= '0;
      valid_q       <= '0;
      commit_fail_q <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      pending_q     <= pending_d;
      valid_q       <= valid_d;
      commit_fail_q <= (res == CommitFail);
      dropped_q     <= (res == CommitDrop);
    end
  end

  assign wr_sel      = wr_sel_q;
  assign rd_sel      = rd_sel_q;
  assign pending     = pending_q;
  assign commit_fail = commit_fail_q;
  assign dropped     = dropped_q;

endmodule

// File: rtl/pp_ram_mq.sv
// pp_ram_mq: multi-slot frame buffer. The writer fills the current write slot and
// commits it with flags and length; the reader consumes committed slots in FIFO order.
// Optional feature macro: PP_RAM_MQ_PARITY_EN (even parity per word, rd_parity_err port).
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   rd_addr, rd_done, flush           read address, release oldest slot, discard all
//   rd_data, rd_flags, rd_len         registered view of oldest slot (0 when empty)
//   unread, pending                   pending != 0, committed unread slot count
//   wr_data, wr_addr, wr_en           write port into the current write slot
//   wr_abort, commit, wr_flags, wr_len  commit control and captured metadata
//   overwrite_en                      when full, commit drops oldest
//   commit_fail, dropped              one-cycle status pulses
//   rd_parity_err                     (PP_RAM_MQ_PARITY_EN only) parity mismatch on rd_data
module pp_ram_mq
  import pp_ram_mq_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned N_WIDTH = 1,
  parameter int unsigned F_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [D_WIDTH-1:0] rd_data,
  input  logic [A_WIDTH-1:0] rd_addr,
  input  logic               rd_done,
  input  logic               flush,
  output logic               unread,
  output logic [N_WIDTH:0]   pending,
  output logic [F_WIDTH-1:0] rd_flags,
  output logic [A_WIDTH:0]   rd_len,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic               wr_en,
  input  logic               wr_abort,
  input  logic               commit,
  input  logic [F_WIDTH-1:0] wr_flags,
  input  logic [A_WIDTH:0]   wr_len,
  input  logic               overwrite_en,
  output logic               commit_fail,
  output logic               dropped
`ifdef PP_RAM_MQ_PARITY_EN
  ,
  output logic               rd_parity_err
`endif
);

  localparam int unsigned S     = slot_count(N_WIDTH);
  localparam int unsigned Depth = S << A_WIDTH;

  logic [N_WIDTH-1:0] wr_sel, rd_sel;
  logic               store;

  pp_ram_mq_ctrl #(
    .N_WIDTH(N_WIDTH)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .rd_done     (rd_done),
    .commit      (commit),
    .wr_abort    (wr_abort),
    .overwrite_en(overwrite_en),
    .wr_sel      (wr_sel),
    .rd_sel      (rd_sel),
    .pending     (pending),
    .store       (store),
    .commit_fail (commit_fail),
    .dropped     (dropped)
  );

  assign unread = (pending != '0);

  // Word storage is flat: index = {slot, address}.
  logic [D_WIDTH-1:0] mem [Depth];
  logic [F_WIDTH-1:0] flags_mem [S];
  logic [A_WIDTH:0]   len_mem [S];

  logic [N_WIDTH+A_WIDTH-1:0] wr_idx, rd_idx;
  assign wr_idx = {wr_sel, wr_addr};
  assign rd_idx = {rd_sel, rd_addr};

  // RAM has no reset; writes land even during flush.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (store) begin
      flags_mem[wr_sel] <= wr_flags;
      len_mem[wr_sel]   <= wr_len;
    end
  end

  logic [D_WIDTH-1:0] rd_data_q;
  logic [F_WIDTH-1:0] rd_flags_q;
  logic [A_WIDTH:0]   rd_len_q;

  // Flush also blanks the read registers so the cycle after a flush reads as empty.
  always_ff @(posedge clk) begin
    if (reset || flush || (pending == '0)) begin
      rd_data_q  <= '0;
      rd_flags_q <= '0;
      rd_len_q   <= '0;
    end else begin
      rd_data_q  <= mem[rd_idx];
      rd_flags_q <= flags_mem[rd_sel];
      rd_len_q   <= len_mem[rd_sel];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_flags = rd_flags_q;
  assign rd_len   = rd_len_q;

`ifdef PP_RAM_MQ_PARITY_EN
  logic par_mem [Depth];
  logic rd_parity_err_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem[wr_idx] <= ^wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush || (pending == '0)) begin
      rd_parity_err_q <= 1'b0;
    end else begin
      rd_parity_err_q <= (^mem[rd_idx]) ^ par_mem[rd_idx];
    end
  end

  assign rd_parity_err = rd_parity_err_q;
`endif

endmodule

// File: tb/tb_pp_ram_mq.sv
// Directed, table-driven bench for pp_ram_mq (D_WIDTH=8, A_WIDTH=4, N_WIDTH=2, F_WIDTH=8).
module tb_pp_ram_mq;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned NW = 2;
  localparam int unsigned FW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic          rd_done;
  logic          flush;
  logic          unread;
  logic [NW:0]   pending;
  logic [FW-1:0] rd_flags;
  logic [AW:0]   rd_len;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          wr_abort;
  logic          commit;
  logic [FW-1:0] wr_flags;
  logic [AW:0]   wr_len;
  logic          overwrite_en;
  logic          commit_fail;
  logic          dropped;
`ifdef PP_RAM_MQ_PARITY_EN
  logic          rd_parity_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pp_ram_mq #(
    .D_WIDTH(DW),
    .A_WIDTH(AW),
    .N_WIDTH(NW),
    .F_WIDTH(FW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_data     (rd_data),
    .rd_addr     (rd_addr),
    .rd_done     (rd_done),
    .flush       (flush),
    .unread      (unread),
    .pending     (pending),
    .rd_flags    (rd_flags),
    .rd_len      (rd_len),
    .wr_data     (wr_data),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .wr_abort    (wr_abort),
    .commit      (commit),
    .wr_flags    (wr_flags),
    .wr_len      (wr_len),
    .overwrite_en(overwrite_en),
    .commit_fail (commit_fail),
    .dropped     (dropped)
`ifdef PP_RAM_MQ_PARITY_EN
    ,
    .rd_parity_err(rd_parity_err)
`endif
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          cm;
    logic          ab;
    logic [FW-1:0] fl;
    logic [AW:0]   ln;
    logic          rdn;
    logic [AW-1:0] ra;
    logic          ow;
    logic [NW:0]   e_pend;
    logic          chkd;
    logic [DW-1:0] e_data;
    logic [FW-1:0] e_fl;
    logic [AW:0]   e_len;
    logic          e_fail;
    logic          e_drop;
  } vec_t;

  localparam int NVec = 25;
  vec_t vecs [NVec];

  function automatic vec_t mk(input logic we, input int wa, input int wd, input logic cm,
                              input logic ab, input int fl, input int ln, input logic rdn,
                              input int ra, input logic ow, input int e_pend,
                              input logic chkd, input int e_data, input int e_fl,
                              input int e_len, input logic e_fail, input logic e_drop);
    vec_t v;
    v.we = we;     v.wa = AW'(wa);  v.wd = DW'(wd);  v.cm = cm;  v.ab = ab;
    v.fl = FW'(fl); v.ln = (AW+1)'(ln); v.rdn = rdn; v.ra = AW'(ra); v.ow = ow;
    v.e_pend = (NW+1)'(e_pend); v.chkd = chkd; v.e_data = DW'(e_data);
    v.e_fl = FW'(e_fl); v.e_len = (AW+1)'(e_len); v.e_fail = e_fail; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_pend, input logic chkd, input int e_data,
                         input int e_fl, input int e_len, input logic e_fail,
                         input logic e_drop);
    chk({tag, " pending"}, 32'(pending), 32'(e_pend));
    chk({tag, " unread"}, 32'(unread), 32'(e_pend != 0));
    if (chkd) chk({tag, " rd_data"}, 32'(rd_data), 32'(e_data));
    chk({tag, " rd_flags"}, 32'(rd_flags), 32'(e_fl));
    chk({tag, " rd_len"}, 32'(rd_len), 32'(e_len));
    chk({tag, " commit_fail"}, 32'(commit_fail), 32'(e_fail));
    chk({tag, " dropped"}, 32'(dropped), 32'(e_drop));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0; commit = 0; wr_abort = 0; wr_flags = '0;
    wr_len = '0; rd_done = 0; rd_addr = '0; overwrite_en = 0; flush = 0;
  endtask

  initial begin
    //            we wa wd    cm ab fl     ln rdn ra ow  pend chkd data  fl     len fail drop
    vecs[0]  = mk(1, 0, 'h11, 0, 0, 0,     0, 0,  0, 0,  0,   1,   0,    0,     0,  0,   0);
    vecs[1]  = mk(1, 1, 'h12, 0, 0, 0,     0, 0,  0, 0,  0,   1,   0,    0,     0,  0,   0);
    vecs[2]  = mk(1, 2, 'h13, 0, 0, 0,     0, 0,  0, 0,  0,   1,   0,    0,     0,  0,   0);
    vecs[3]  = mk(1, 3, 'h14, 1, 0, 'h5A,  4, 0,  0, 0,  1,   1,   0,    0,     0,  0,   0);
    vecs[4]  = mk(0, 0, 0,    0, 0, 0,     0, 0,  0, 0,  1,   1,   'h11, 'h5A,  4,  0,   0);
    vecs[5]  = mk(0, 0, 0,    0, 0, 0,     0, 0,  1, 0,  1,   1,   'h12, 'h5A,  4,  0,   0);
    vecs[6]  = mk(0, 0, 0,    0, 0, 0,     0, 0,  2, 0,  1,   1,   'h13, 'h5A,  4,  0,   0);
    vecs[7]  = mk(0, 0, 0,    0, 0, 0,     0, 0,  3, 0,  1,   1,   'h14, 'h5A,  4,  0,   0);
    // fill to full, then a refused commit
    vecs[8]  = mk(1, 0, 'hA1, 1, 0, 'h21,  1, 0,  0, 0,  2,   1,   'h11, 'h5A,  4,  0,   0);
    vecs[9]  = mk(0, 0, 0,    1, 0, 'h22,  2, 0,  0, 0,  3,   1,   'h11, 'h5A,  4,  0,   0);
    vecs[10] = mk(0, 0, 0,    1, 0, 'h23,  3, 0,  0, 0,  3,   1,   'h11, 'h5A,  4,  1,   0);
    vecs[11] = mk(0, 0, 0,    0, 0, 0,     0, 0,  0, 0,  3,   1,   'h11, 'h5A,  4,  0,   0);
    // release + commit while full
    vecs[12] = mk(0, 0, 0,    1, 0, 'h33,  5, 1,  0, 0,  3,   1,   'h11, 'h5A,  4,  0,   0);
    vecs[13] = mk(0, 0, 0,    0, 0, 0,     0, 0,  0, 0,  3,   1,   'hA1, 'h21,  1,  0,   0);
    // overwrite-oldest
    vecs[14] = mk(1, 0, 'hB0, 1, 0, 'h44,  6, 0,  0, 1,  3,   1,   'hA1, 'h21,  1,  0,   1);
    vecs[15] = mk(0, 0, 0,    0, 0, 0,     0, 0,  0, 0,  3,   0,   0,    'h22,  2,  0,   0);
    vecs[16] = mk(0, 0, 0,    0, 0, 0,     0, 1,  0, 0,  2,   0,   0,    'h22,  2,  0,   0);
    vecs[17] = mk(0, 0, 0,    0, 0, 0,     0, 1,  0, 0,  1,   0,   0,    'h33,  5,  0,   0);
    vecs[18] = mk(0, 0, 0,    0, 0, 0,     0, 0,  0, 0,  1,   1,   'hB0, 'h44,  6,  0,   0);
    vecs[19] = mk(0, 0, 0,    0, 0, 0,     0, 1,  0, 0,  0,   1,   'hB0, 'h44,  6,  0,   0);
    vecs[20] = mk(0, 0, 0,    0, 0, 0,     0, 0,  0, 0,  0,   1,   0,    0,     0,  0,   0);
    // release when empty, abort beats commit
    vecs[21] = mk(0, 0, 0,    0, 0, 0,     0, 1,  0, 0,  0,   1,   0,    0,     0,  0,   0);
    vecs[22] = mk(0, 0, 0,    1, 1, 'h99,  9, 0,  0, 0,  0,   1,   0,    0,     0,  0,   0);
    vecs[23] = mk(0, 0, 0,    1, 0, 'h55,  7, 0,  0, 0,  1,   1,   0,    0,     0,  0,   0);
    vecs[24] = mk(0, 0, 0,    0, 0, 0,     0, 0,  0, 0,  1,   1,   'hA1, 'h55,  7,  0,   0);

    idle_inputs();
    reset = 1;
    step();
    step();
    chk_all("reset", 0, 1, 0, 0, 0, 0, 0);
`ifdef PP_RAM_MQ_PARITY_EN
    chk("reset rd_parity_err", 32'(rd_parity_err), 0);
`endif
    reset = 0;

    for (int i = 0; i < NVec; i++) begin
      wr_en = vecs[i].we;  wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      commit = vecs[i].cm; wr_abort = vecs[i].ab; wr_flags = vecs[i].fl;
      wr_len = vecs[i].ln; rd_done = vecs[i].rdn; rd_addr = vecs[i].ra;
      overwrite_en = vecs[i].ow;
      step();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].e_pend), vecs[i].chkd,
              int'(vecs[i].e_data), int'(vecs[i].e_fl), int'(vecs[i].e_len),
              vecs[i].e_fail, vecs[i].e_drop);
    end
    idle_inputs();

    // flush together with commit, rd_done and a write
    flush = 1; commit = 1; wr_flags = 'h66; wr_len = 2; rd_done = 1;
    wr_en = 1; wr_addr = 5; wr_data = 'h77;
    step();
    chk_all("flush", 0, 1, 0, 0, 0, 0, 0);
    idle_inputs();
    step();
    chk_all("post_flush", 0, 1, 0, 0, 0, 0, 0);

    // sync reset in the middle of a write
    wr_en = 1; wr_addr = 0; wr_data = 'hC3; commit = 1; wr_flags = 'h88; wr_len = 3;
    step();
    chk_all("pre_reset_commit", 1, 1, 0, 0, 0, 0, 0);
    idle_inputs();
    step();
    chk_all("pre_reset_read", 1, 1, 'hC3, 'h88, 3, 0, 0);
    reset = 1; wr_en = 1; wr_addr = 1; wr_data = 'hD4; commit = 1; wr_flags = 'h99;
    step();
    chk_all("mid_reset", 0, 1, 0, 0, 0, 0, 0);
    idle_inputs();
    reset = 0;
    step();
    chk_all("post_reset", 0, 1, 0, 0, 0, 0, 0);

`ifdef PP_RAM_MQ_PARITY_EN
    // wr_sel is 0 after reset: slot 0 words 2 and 3, then corrupt word 2's parity
    wr_en = 1; wr_addr = 2; wr_data = 'h5C;
    step();
    wr_addr = 3; wr_data = 'h3A; commit = 1; wr_flags = 'h01; wr_len = 4;
    step();
    idle_inputs();
    dut.par_mem[2] = ~dut.par_mem[2];
    rd_addr = 2;
    step();
    chk("par rd_data bad", 32'(rd_data), 'h5C);
    chk("par err set", 32'(rd_parity_err), 1);
    rd_addr = 3;
    step();
    chk("par rd_data good", 32'(rd_data), 'h3A);
    chk("par err clear", 32'(rd_parity_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
